turn_sequencer: RTL and testbench

- Game-flow controller sitting above one player_controller instance per player.
- Converts a roll button press into a pseudo-random dice value (1..3). Issues a one-cycle move_1/move_2/move_3 command to the active player only, then waits for that player's animation to finish.
- After the move it checks the goal tile, then either declares a winner or passes the turn to the next player round-robin.
- Outputs also drive the HUD (active player, dice value, turn count, winner).

---
 rtl/turn_sequencer.sv | 151 +++++++++++++++
 tb/tb_turn_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/turn_sequencer.sv
// Turn sequencer: turns a roll press into a dice value, issues a one-cycle move
// command to the active player, waits for the move to finish, then checks for a winner.
module turn_sequencer #(
    parameter int         NUM_PLAYERS   = 2,
    parameter int         GOAL_TILE     = 9,
    parameter int         START_TIMEOUT = 7,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     roll_btn,
    input  logic [NUM_PLAYERS-1:0]   p_is_moving,
    input  logic [4*NUM_PLAYERS-1:0] p_tile,
    output logic [NUM_PLAYERS-1:0]   move_1,
    output logic [NUM_PLAYERS-1:0]   move_2,
    output logic [NUM_PLAYERS-1:0]   move_3,
    output logic [1:0]               active_player,
    output logic [1:0]               dice_value,
    output logic                     busy,
    output logic                     winner_valid,
    output logic [1:0]               winner_id,
    output logic [7:0]               turn_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_ROLL, S_ISSUE, S_WAIT_START, S_WAIT_DONE, S_CHECK, S_GAME_OVER
    } state_t;

    localparam logic [1:0] LAST_PLAYER = 2'(NUM_PLAYERS - 1);
    localparam logic [3:0] GOAL        = 4'(GOAL_TILE);
    localparam logic [7:0] TO_LAST     = 8'(START_TIMEOUT - 1);

    state_t                 r_state;
    logic [7:0]             r_lfsr;
    logic                   r_roll_prev;
    logic [7:0]             r_cnt;
    logic [NUM_PLAYERS-1:0] r_move1, r_move2, r_move3;
    logic [1:0]             r_ap, r_dice, r_wid;
    logic                   r_busy, r_win;
    logic [7:0]             r_turn;

    logic                   w_roll_pulse;
    logic                   w_fb;
    logic [1:0]             w_dice;
    logic [1:0]             w_next_ap;
    logic [NUM_PLAYERS-1:0] w_sel;
    logic                   w_moving;
    logic [3:0]             w_tile;

    assign w_roll_pulse = roll_btn & ~r_roll_prev;
    assign w_fb         = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_dice       = 2'(r_lfsr % 8'd3) + 2'd1;
    assign w_next_ap    = (r_ap == LAST_PLAYER) ? 2'd0 : r_ap + 2'd1;

    // Only the active player's moving flag and tile are ever looked at.
    always_comb begin
        w_sel    = '0;
        w_moving = 1'b0;
        w_tile   = 4'd0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (r_ap == 2'(i)) begin
                w_sel[i] = 1'b1;
                w_moving = p_is_moving[i];
                w_tile   = p_tile[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lfsr      <= LFSR_SEED;
            r_roll_prev <= 1'b0;
            r_cnt       <= 8'd0;
            r_move1     <= '0;
            r_move2     <= '0;
            r_move3     <= '0;
            r_ap        <= 2'd0;
            r_dice      <= 2'd0;
            r_busy      <= 1'b0;
            r_win       <= 1'b0;
            r_wid       <= 2'd0;
            r_turn      <= 8'd0;
        end else begin
            r_lfsr      <= {r_lfsr[6:0], w_fb};
            r_roll_prev <= roll_btn;
            r_move1     <= '0;
            r_move2     <= '0;
            r_move3     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_roll_pulse) begin
                        r_state <= S_ROLL;
                        r_busy  <= 1'b1;
                    end
                end
                S_ROLL: begin
                    r_dice  <= w_dice;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (r_dice == 2'd1) r_move1 <= w_sel;
                    if (r_dice == 2'd2) r_move2 <= w_sel;
                    if (r_dice == 2'd3) r_move3 <= w_sel;
                    r_cnt   <= 8'd0;
                    r_state <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (w_moving) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        // A player already on the goal never starts moving; give up after the timeout.
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == TO_LAST) r_state <= S_CHECK;
                    end
                end
                S_WAIT_DONE: begin
                    if (!w_moving) r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (r_turn != 8'hFF) r_turn <= r_turn + 8'd1;
                    r_busy <= 1'b0;
                    if (w_tile >= GOAL) begin
                        r_wid   <= r_ap;
                        r_win   <= 1'b1;
                        r_state <= S_GAME_OVER;
                    end else begin
                        r_ap    <= w_next_ap;
                        r_state <= S_IDLE;
                    end
                end
                S_GAME_OVER: r_state <= S_GAME_OVER;
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign move_1        = r_move1;
    assign move_2        = r_move2;
    assign move_3        = r_move3;
    assign active_player = r_ap;
    assign dice_value    = r_dice;
    assign busy          = r_busy;
    assign winner_valid  = r_win;
    assign winner_id     = r_wid;
    assign turn_count    = r_turn;

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: random move lengths and tiles against a turn-level model
// of the game (dice from the spec LFSR, round-robin turns, goal check).
module tb_turn_sequencer;

    localparam int         NP   = 2;
    localparam int         GOAL = 9;
    localparam int         TO   = 7;
    localparam logic [7:0] SEED = 8'hA5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            roll_btn = 1'b0;
    logic [NP-1:0]   p_is_moving = '0;
    logic [4*NP-1:0] p_tile = '0;
    logic [NP-1:0]   move_1, move_2, move_3;
    logic [1:0]      active_player, dice_value, winner_id;
    logic            busy, winner_valid;
    logic [7:0]      turn_count;

    int checks = 0;
    int passed = 0;

    logic [7:0] m_lfsr;
    int         m_ap = 0;
    int         m_turn = 0;
    logic [1:0] m_dice = 2'd0;
    bit         m_win = 1'b0;
    int         m_wid = 0;

    turn_sequencer #(.NUM_PLAYERS(NP), .GOAL_TILE(GOAL), .START_TIMEOUT(TO), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .roll_btn(roll_btn), .p_is_moving(p_is_moving), .p_tile(p_tile),
        .move_1(move_1), .move_2(move_2), .move_3(move_3), .active_player(active_player),
        .dice_value(dice_value), .busy(busy), .winner_valid(winner_valid), .winner_id(winner_id),
        .turn_count(turn_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Dice source: seed while reset is held, one shift per clock otherwise.
    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic set_tile(input int p, input logic [3:0] v);
        p_tile[4*p +: 4] = v;
    endtask

    task automatic check_end_of_turn(input string name);
        checks++;
        if (turn_count !== 8'(m_turn) || active_player !== 2'(m_ap) || busy !== 1'b0 || winner_valid !== m_win)
            $display("FAIL %s end-of-turn: turn=%0d ap=%0d busy=%b win=%b, required turn=%0d ap=%0d busy=0 win=%b",
                     name, turn_count, active_player, busy, winner_valid, m_turn, m_ap, m_win);
        else passed++;
        if (m_win) begin
            checks++;
            if (winner_id !== 2'(m_wid)) $display("FAIL %s winner_id: got %0d required %0d", name, winner_id, m_wid);
            else passed++;
        end
    endtask

    // One full turn. mv_cycles=0 models a player that never starts moving.
    task automatic play_turn(input string name, input int mv_cycles, input logic [3:0] new_tile, input bit press_during);
        int ap;
        int n;
        logic [1:0] d;
        logic [NP-1:0] oh;
        ap = m_ap;
        oh = '0;
        oh[ap] = 1'b1;
        @(negedge clk) roll_btn = 1'b1;
        @(posedge clk); #1;
        d = 2'((int'(m_lfsr) % 3) + 1);
        checks++;
        if (busy !== 1'b1) $display("FAIL %s busy-in-roll: got %b required 1", name, busy);
        else passed++;
        @(negedge clk) roll_btn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({move_3, move_2, move_1} !== '0 || dice_value !== d)
            $display("FAIL %s issue-cycle: moves=%h dice=%0d required moves=0 dice=%0d", name, {move_3, move_2, move_1}, dice_value, d);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (move_1 !== ((d == 2'd1) ? oh : '0) || move_2 !== ((d == 2'd2) ? oh : '0) || move_3 !== ((d == 2'd3) ? oh : '0))
            $display("FAIL %s move-pulse: m1=%b m2=%b m3=%b required dice %0d on player %0d", name, move_1, move_2, move_3, d, ap);
        else passed++;
        m_dice = d;
        if (mv_cycles > 0) begin
            @(negedge clk);
            p_is_moving[ap] = 1'b1;
            set_tile(ap, new_tile);
            for (int i = 0; i < mv_cycles; i++) begin
                @(negedge clk);
                checks++;
                if ({move_3, move_2, move_1} !== '0 || dice_value !== d || busy !== 1'b1)
                    $display("FAIL %s while-moving: moves=%h dice=%0d busy=%b required moves=0 dice=%0d busy=1",
                             name, {move_3, move_2, move_1}, dice_value, busy, d);
                else passed++;
                if (press_during) roll_btn = i[0];
            end
            roll_btn = 1'b0;
            p_is_moving[ap] = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b1) $display("FAIL %s check-cycle busy: got %b required 1", name, busy);
            else passed++;
            @(posedge clk); #1;
        end else begin
            set_tile(ap, new_tile);
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                @(posedge clk); #1;
                n++;
                if ({move_3, move_2, move_1} !== '0) begin
                    checks++;
                    $display("FAIL %s timeout-extra-pulse: moves=%h required 0", name, {move_3, move_2, move_1});
                end
            end
            checks++;
            if (n < TO || n > TO + 3) $display("FAIL %s timeout-length: got %0d cycles required %0d..%0d", name, n, TO, TO + 3);
            else passed++;
        end
        m_turn = (m_turn < 255) ? m_turn + 1 : 255;
        if (int'(new_tile) >= GOAL) begin
            m_win = 1'b1;
            m_wid = ap;
        end else begin
            m_ap = (m_ap + 1) % NP;
        end
        check_end_of_turn(name);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if ({move_3, move_2, move_1} !== '0 || active_player !== 2'd0 || dice_value !== 2'd0 || busy !== 1'b0 ||
            winner_valid !== 1'b0 || winner_id !== 2'd0 || turn_count !== 8'd0)
            $display("FAIL reset-values: moves=%h ap=%0d dice=%0d busy=%b wv=%b wid=%0d turn=%0d required all 0",
                     {move_3, move_2, move_1}, active_player, dice_value, busy, winner_valid, winner_id, turn_count);
        else passed++;
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dice_value !== 2'd0) $display("FAIL idle-after-reset: busy=%b dice=%0d required 0/0", busy, dice_value);
        else passed++;
    endtask

    task automatic test_reset_mid_move();
        @(negedge clk) roll_btn = 1'b1;
        @(negedge clk) roll_btn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) p_is_moving[m_ap] = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({move_3, move_2, move_1} !== '0 || active_player !== 2'd0 || dice_value !== 2'd0 || busy !== 1'b0 ||
            winner_valid !== 1'b0 || winner_id !== 2'd0 || turn_count !== 8'd0)
            $display("FAIL mid-move-reset: moves=%h ap=%0d dice=%0d busy=%b wv=%b turn=%0d required all 0",
                     {move_3, move_2, move_1}, active_player, dice_value, busy, winner_valid, turn_count);
        else passed++;
        m_ap = 0; m_turn = 0; m_dice = 2'd0; m_win = 1'b0;
        p_is_moving = '0;
        p_tile = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({move_3, move_2, move_1} !== '0 || busy !== 1'b0)
                $display("FAIL after-reset-quiet: moves=%h busy=%b required 0/0", {move_3, move_2, move_1}, busy);
            else passed++;
        end
    endtask

    task automatic test_game_over();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk) roll_btn = i[1];
            #2;
            checks++;
            if ({move_3, move_2, move_1} !== '0 || winner_valid !== 1'b1 || winner_id !== 2'(m_wid) ||
                active_player !== 2'(m_ap) || dice_value !== m_dice || busy !== 1'b0)
                $display("FAIL game-over-hold: moves=%h wv=%b wid=%0d ap=%0d dice=%0d busy=%b required 0/1/%0d/%0d/%0d/0",
                         {move_3, move_2, move_1}, winner_valid, winner_id, active_player, dice_value, busy, m_wid, m_ap, m_dice);
            else passed++;
        end
        roll_btn = 1'b0;
    endtask

    initial begin
        test_reset();
        play_turn("first_roll", 40, 4'd2, 1'b1);
        play_turn("timeout", 0, 4'd0, 1'b0);
        test_reset_mid_move();
        for (int t = 0; t < 4; t++)
            play_turn("random_turn", int'($urandom_range(1, 10)), (t == 2) ? 4'd8 : 4'($urandom_range(0, 8)),
                      1'($urandom_range(0, 1)));
        if (m_ap != 1) play_turn("pre_winner", 3, 4'd3, 1'b0);
        play_turn("winner", 5, 4'd9, 1'b0);
        test_game_over();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
